q_learning_controller: RTL and testbench
========================================

# q_learning_controller

Sequencer for one Q-learning agent. Per step it reads the current state's Q row, drives the PolicyGenerator with that row and the current epsilon, and issues the selected action to the environment. It then reads the next-state row and hands a complete update packet to the Q-update datapath. It also owns the per-episode epsilon decay schedule and sits between the Q-table RAM, PolicyGenerator, environment model and Q-update unit.

## Interface
- `S_W`, default 4: state index width (16 states).
- `POLICY_LAT`, default 1: cycles from stable `pol_q_values` to valid `pol_action`.
- `MAX_STEPS`, default 255: step limit per episode (8-bit).
- `EPS_INIT`, default 16'h00E0: reset epsilon, unsigned Q8.8 (0.875).
- `EPS_MIN`, default 16'h0010: epsilon floor (0.0625).
- `EPS_SHIFT`, default 3: per-episode decay, eps -= eps >> EPS_SHIFT.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin episode; ignored unless idle.
- `start_state` in S_W: initial state, sampled with `start`.
- `abort` in 1: return to IDLE at next edge; no update, no decay.
- `qt_rd_en` out 1, `qt_rd_addr` out S_W: Q-table read; data valid 1 cycle later.
- `qt_rd_data` in 64: 4 × signed Q8.8 Q values, action0 at [15:0].
- `pol_q_values` out 64, `pol_epsilon` out 16: PolicyGenerator inputs.
- `pol_action` in 4: one-hot action from PolicyGenerator.
- `env_req` out 1, `env_action` out 4: action request, held until ack.
- `env_ack` in 1, `env_reward` in 16 (signed Q8.8), `env_next_state` in S_W, `env_done` in 1: environment response, valid with ack.
- `upd_valid` out 1, `upd_ready` in 1: update handshake.
- `upd_state` out S_W, `upd_action` out 4, `upd_reward` out 16, `upd_q_cur` out 64, `upd_q_next` out 64: update payload.
- `busy` out 1, `episode_done` out 1 (pulse), `step_count` out 8, `epsilon` out 16, `act_err` out 1 (sticky).

## Operation
- FSM: IDLE → RD_CUR → CAP_CUR → POLICY → ENV → RD_NXT → CAP_NXT → UPDATE → (RD_CUR | DECAY) → IDLE.
- IDLE: on `start`, latch `start_state`, clear `step_count`, go to RD_CUR.
- RD_CUR: `qt_rd_en`=1 for one cycle with `qt_rd_addr`=state.
- CAP_CUR: capture `qt_rd_data` into the current row. `pol_q_values` = current row and `pol_epsilon` = `epsilon`, both held constant outside DECAY.
- POLICY: wait POLICY_LAT cycles, then latch `pol_action`.
  - Not one-hot (zero or more than one bit set): set `act_err`, substitute 4'b0001.
- ENV: `env_req`=1 with stable `env_action` until `env_ack`. On ack, latch reward, next state and done. `env_req` is low the following cycle.
- RD_NXT/CAP_NXT: read and capture the `env_next_state` row.
- UPDATE: `upd_valid`=1 with a stable payload until `upd_ready`. On handshake, `step_count`++.
  - Go to DECAY if done, or if the post-increment `step_count` == MAX_STEPS.
  - Otherwise state ← next_state and go to RD_CUR.
- DECAY: eps_new = eps − (eps >> EPS_SHIFT), computed unsigned. If eps_new < EPS_MIN, eps ← EPS_MIN. Pulse `episode_done` for 1 cycle, go to IDLE.
- `abort` has priority over every transition: it drops all handshake outputs the next cycle and keeps `epsilon` and `act_err`.
- `busy` = (state != IDLE).
- `start` while busy: ignored.
- `start` together with `abort` in IDLE: `abort` wins.
- `act_err` is cleared only by reset.

## Timing
- Reset (async, immediate): state IDLE; all handshake, read and pulse outputs 0; payload and row registers 0; `step_count` 0; `epsilon` = `pol_epsilon` = EPS_INIT; `act_err` 0.
- Reset mid-handshake: `env_req`/`upd_valid` drop asynchronously. The partner must tolerate request withdrawal under reset only.
- Zero-wait step latency (ack and ready high): 1+1+POLICY_LAT+1+1+1+1 cycles = 7 with default POLICY_LAT.
- `epsilon` changes only on the DECAY→IDLE edge.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `QCTRL_EVAL_MODE_EN` defined: adds input `eval_mode` (1 bit), sampled with `start`.
  - When set, the episode runs greedy: `pol_epsilon` = 0, UPDATE is skipped (CAP_NXT goes straight to the step-count/done check), and DECAY skips the epsilon change but still pulses `episode_done`.
- Not defined: the port is absent and every episode trains.

## Structure
- Package `rl_pkg`:
  - Q_W=16, N_ACT=4, ROW_W=64.
  - Q8.8 format constants.
  - FSM state enum.
  - One-hot check function.
- Sub-module `epsilon_scheduler`: epsilon register, decay/clamp arithmetic, `decay` strobe input.

## Test plan
- Reset: `rst_n` low mid-ENV → `env_req`=0 immediately, `epsilon`=16'h00E0, `busy`=0.
- Single step: start_state=2, row 0x000C_0001_0002_0003, policy returns 4'b0100, ack with reward 16'h0100, next=5, done=1 → `upd_state`=2, `upd_action`=4'b0100, `upd_q_cur` = row 2 contents, one `episode_done` pulse, `epsilon`=16'h00C4.
- Decay floor: episodes until eps=16'h0010, then one more → stays 16'h0010 (16−2 < 16 clamps).
- Step limit: env never signals done, MAX_STEPS=3 → exactly 3 update handshakes, then DECAY.
- Backpressure and abort: `upd_ready` low 5 cycles → payload stable and `upd_valid` held; `abort` in UPDATE → IDLE next cycle, epsilon unchanged.
- Bad action: `pol_action`=4'b0110 → `act_err`=1, `env_action`=4'b0001.

Source files
------------

// File: rtl/rl_pkg.sv
// Shared types and constants for the Q-learning agent: Q8.8 widths,
// action encoding, sequencer state enum and the one-hot action check.
package rl_pkg;

    localparam int unsigned Q_FRAC_W = 8;
    localparam int unsigned Q_INT_W  = 8;
    localparam int unsigned Q_W      = Q_INT_W + Q_FRAC_W;
    localparam int unsigned N_ACT    = 4;
    localparam int unsigned ROW_W    = N_ACT * Q_W;

    localparam logic [Q_W-1:0]   Q_ZERO      = '0;
    localparam logic [N_ACT-1:0] ACT_DEFAULT = N_ACT'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CUR,
        S_CAP_CUR,
        S_POLICY,
        S_ENV,
        S_RD_NXT,
        S_CAP_NXT,
        S_UPDATE,
        S_DECAY
    } fsm_state_t;

    // True when exactly one action bit is set
    function automatic logic is_onehot(input logic [N_ACT-1:0] a);
        return (a != '0) && ((a & (a - N_ACT'(1))) == '0);
    endfunction

endpackage

// File: rtl/q_learning_controller_epsilon.sv
// Per-episode epsilon register: eps -= eps >> EPS_SHIFT on each decay
// strobe, clamped to EPS_MIN. Arithmetic is unsigned Q8.8.
module epsilon_scheduler
    import rl_pkg::*;
#(
    parameter logic [Q_W-1:0] EPS_INIT  = 16'h00E0,
    parameter logic [Q_W-1:0] EPS_MIN   = 16'h0010,
    parameter int unsigned    EPS_SHIFT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           decay,
    output logic [Q_W-1:0] epsilon
);

    logic [Q_W-1:0] r_eps;
    logic [Q_W-1:0] w_eps_dec;

    assign w_eps_dec = r_eps - (r_eps >> EPS_SHIFT);
    assign epsilon   = r_eps;

    // Epsilon register, only moves on the decay strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eps <= EPS_INIT;
        end else if (decay) begin
            r_eps <= (w_eps_dec < EPS_MIN) ? EPS_MIN : w_eps_dec;
        end
    end

endmodule

// File: rtl/q_learning_controller.sv
// Step sequencer for one Q-learning agent: reads the current Q row, runs the
// policy, drives the environment, reads the next-state row and hands an update
// packet to the Q-update datapath; decays epsilon once per episode.
// Optional build macro: QCTRL_EVAL_MODE_EN adds the eval_mode input (greedy,
// no updates, no epsilon decay for that episode).
module q_learning_controller
    import rl_pkg::*;
#(
    parameter int unsigned    S_W        = 4,
    parameter int unsigned    POLICY_LAT = 1,
    parameter int unsigned    MAX_STEPS  = 255,
    parameter logic [Q_W-1:0] EPS_INIT   = 16'h00E0,
    parameter logic [Q_W-1:0] EPS_MIN    = 16'h0010,
    parameter int unsigned    EPS_SHIFT  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [S_W-1:0]     start_state,
`ifdef QCTRL_EVAL_MODE_EN
    input  logic               eval_mode,
`endif
    input  logic               abort,
    output logic               qt_rd_en,
    output logic [S_W-1:0]     qt_rd_addr,
    input  logic [ROW_W-1:0]   qt_rd_data,
    output logic [ROW_W-1:0]   pol_q_values,
    output logic [Q_W-1:0]     pol_epsilon,
    input  logic [N_ACT-1:0]   pol_action,
    output logic               env_req,
    output logic [N_ACT-1:0]   env_action,
    input  logic               env_ack,
    input  logic [Q_W-1:0]     env_reward,
    input  logic [S_W-1:0]     env_next_state,
    input  logic               env_done,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [S_W-1:0]     upd_state,
    output logic [N_ACT-1:0]   upd_action,
    output logic [Q_W-1:0]     upd_reward,
    output logic [ROW_W-1:0]   upd_q_cur,
    output logic [ROW_W-1:0]   upd_q_next,
    output logic               busy,
    output logic               episode_done,
    output logic [7:0]         step_count,
    output logic [Q_W-1:0]     epsilon,
    output logic               act_err
);

    localparam int unsigned SC_W = 8;
    localparam int unsigned PC_W = 8;

    fsm_state_t       r_fsm;
    logic [S_W-1:0]   r_cur_state;
    logic [S_W-1:0]   r_next_state;
    logic [S_W-1:0]   r_qt_rd_addr;
    logic             r_qt_rd_en;
    logic             r_env_req;
    logic             r_upd_valid;
    logic             r_busy;
    logic             r_episode_done;
    logic             r_act_err;
    logic             r_done;
    logic             r_eval;
    logic [N_ACT-1:0] r_action;
    logic [Q_W-1:0]   r_reward;
    logic [Q_W-1:0]   r_pol_eps;
    logic [ROW_W-1:0] r_q_cur;
    logic [ROW_W-1:0] r_q_next;
    logic [SC_W-1:0]  r_step_count;
    logic [PC_W-1:0]  r_pol_cnt;

    logic [Q_W-1:0]   w_epsilon;
    logic             w_decay;
    logic             w_eval_in;
    logic             w_last;
    logic [SC_W-1:0]  w_step_inc;

`ifdef QCTRL_EVAL_MODE_EN
    assign w_eval_in = eval_mode;
`else
    assign w_eval_in = 1'b0;
`endif

    // Episode ends on env done or when this step reaches the step limit
    assign w_step_inc = r_step_count + SC_W'(1);
    assign w_last     = r_done || (w_step_inc == SC_W'(MAX_STEPS));

    // Decay fires on the DECAY->IDLE edge of a training episode unless aborted
    assign w_decay = (r_fsm == S_DECAY) && !abort && !r_eval;

    epsilon_scheduler #(
        .EPS_INIT  (EPS_INIT),
        .EPS_MIN   (EPS_MIN),
        .EPS_SHIFT (EPS_SHIFT)
    ) u_eps (
        .clk     (clk),
        .rst_n   (rst_n),
        .decay   (w_decay),
        .epsilon (w_epsilon)
    );

    // Step sequencer with registered handshake, read and payload outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm          <= S_IDLE;
            r_cur_state    <= '0;
            r_next_state   <= '0;
            r_qt_rd_addr   <= '0;
            r_qt_rd_en     <= 1'b0;
            r_env_req      <= 1'b0;
            r_upd_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_episode_done <= 1'b0;
            r_act_err      <= 1'b0;
            r_done         <= 1'b0;
            r_eval         <= 1'b0;
            r_action       <= '0;
            r_reward       <= '0;
            r_pol_eps      <= EPS_INIT;
            r_q_cur        <= '0;
            r_q_next       <= '0;
            r_step_count   <= '0;
            r_pol_cnt      <= '0;
        end else begin
            r_qt_rd_en     <= 1'b0;
            r_episode_done <= 1'b0;
            if (abort) begin
                r_fsm       <= S_IDLE;
                r_busy      <= 1'b0;
                r_env_req   <= 1'b0;
                r_upd_valid <= 1'b0;
            end else begin
                case (r_fsm)
                    S_IDLE: begin
                        if (start) begin
                            r_cur_state  <= start_state;
                            r_step_count <= '0;
                            r_eval       <= w_eval_in;
                            r_qt_rd_en   <= 1'b1;
                            r_qt_rd_addr <= start_state;
                            r_busy       <= 1'b1;
                            r_fsm        <= S_RD_CUR;
                        end
                    end
                    S_RD_CUR: begin
                        r_fsm <= S_CAP_CUR;
                    end
                    S_CAP_CUR: begin
                        r_q_cur   <= qt_rd_data;
                        r_pol_eps <= r_eval ? Q_ZERO : w_epsilon;
                        r_pol_cnt <= '0;
                        r_fsm     <= S_POLICY;
                    end
                    S_POLICY: begin
                        if (r_pol_cnt == PC_W'(POLICY_LAT - 1)) begin
                            if (is_onehot(pol_action)) begin
                                r_action <= pol_action;
                            end else begin
                                r_action  <= ACT_DEFAULT;
                                r_act_err <= 1'b1;
                            end
                            r_env_req <= 1'b1;
                            r_fsm     <= S_ENV;
                        end else begin
                            r_pol_cnt <= r_pol_cnt + PC_W'(1);
                        end
                    end
                    S_ENV: begin
                        if (env_ack) begin
                            r_reward     <= env_reward;
                            r_next_state <= env_next_state;
                            r_done       <= env_done;
                            r_env_req    <= 1'b0;
                            r_qt_rd_en   <= 1'b1;
                            r_qt_rd_addr <= env_next_state;
                            r_fsm        <= S_RD_NXT;
                        end
                    end
                    S_RD_NXT: begin
                        r_fsm <= S_CAP_NXT;
                    end
                    S_CAP_NXT: begin
                        r_q_next <= qt_rd_data;
                        if (r_eval) begin
                            r_step_count <= w_step_inc;
                            if (w_last) begin
                                r_fsm <= S_DECAY;
                            end else begin
                                r_cur_state  <= r_next_state;
                                r_qt_rd_en   <= 1'b1;
                                r_qt_rd_addr <= r_next_state;
                                r_fsm        <= S_RD_CUR;
                            end
                        end else begin
                            r_upd_valid <= 1'b1;
                            r_fsm       <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        if (upd_ready) begin
                            r_upd_valid  <= 1'b0;
                            r_step_count <= w_step_inc;
                            if (w_last) begin
                                r_fsm <= S_DECAY;
                            end else begin
                                r_cur_state  <= r_next_state;
                                r_qt_rd_en   <= 1'b1;
                                r_qt_rd_addr <= r_next_state;
                                r_fsm        <= S_RD_CUR;
                            end
                        end
                    end
                    S_DECAY: begin
                        r_episode_done <= 1'b1;
                        r_busy         <= 1'b0;
                        r_fsm          <= S_IDLE;
                    end
                    default: begin
                        r_fsm  <= S_IDLE;
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign qt_rd_en     = r_qt_rd_en;
    assign qt_rd_addr   = r_qt_rd_addr;
    assign pol_q_values = r_q_cur;
    assign pol_epsilon  = r_pol_eps;
    assign env_req      = r_env_req;
    assign env_action   = r_action;
    assign upd_valid    = r_upd_valid;
    assign upd_state    = r_cur_state;
    assign upd_action   = r_action;
    assign upd_reward   = r_reward;
    assign upd_q_cur    = r_q_cur;
    assign upd_q_next   = r_q_next;
    assign busy         = r_busy;
    assign episode_done = r_episode_done;
    assign step_count   = r_step_count;
    assign epsilon      = w_epsilon;
    assign act_err      = r_act_err;

endmodule

// File: tb/tb_q_learning_controller.sv
// Self-checking bench for q_learning_controller: emulates the Q-table RAM,
// PolicyGenerator, environment and update unit, and checks against a
// step-level reference model of the episode/epsilon rules.
module tb_q_learning_controller;

    localparam int unsigned MAXS = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  start_state;
    logic        abort;
    logic        qt_rd_en;
    logic [3:0]  qt_rd_addr;
    logic [63:0] qt_rd_data;
    logic [63:0] pol_q_values;
    logic [15:0] pol_epsilon;
    logic [3:0]  pol_action;
    logic        env_req;
    logic [3:0]  env_action;
    logic        env_ack;
    logic [15:0] env_reward;
    logic [3:0]  env_next_state;
    logic        env_done;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_state;
    logic [3:0]  upd_action;
    logic [15:0] upd_reward;
    logic [63:0] upd_q_cur;
    logic [63:0] upd_q_next;
    logic        busy;
    logic        episode_done;
    logic [7:0]  step_count;
    logic [15:0] epsilon;
    logic        act_err;

    logic [63:0] q_mem [16];
    int          n_vec;
    int          n_err;
    int          cyc;
    int          m_eps;
    logic        m_act_err;

    q_learning_controller #(
        .S_W       (4),
        .POLICY_LAT(1),
        .MAX_STEPS (MAXS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_state   (start_state),
`ifdef QCTRL_EVAL_MODE_EN
        .eval_mode     (1'b0),
`endif
        .abort         (abort),
        .qt_rd_en      (qt_rd_en),
        .qt_rd_addr    (qt_rd_addr),
        .qt_rd_data    (qt_rd_data),
        .pol_q_values  (pol_q_values),
        .pol_epsilon   (pol_epsilon),
        .pol_action    (pol_action),
        .env_req       (env_req),
        .env_action    (env_action),
        .env_ack       (env_ack),
        .env_reward    (env_reward),
        .env_next_state(env_next_state),
        .env_done      (env_done),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_state     (upd_state),
        .upd_action    (upd_action),
        .upd_reward    (upd_reward),
        .upd_q_cur     (upd_q_cur),
        .upd_q_next    (upd_q_next),
        .busy          (busy),
        .episode_done  (episode_done),
        .step_count    (step_count),
        .epsilon       (epsilon),
        .act_err       (act_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Q-table RAM model: one-cycle read latency
    always_ff @(posedge clk) begin
        if (qt_rd_en) qt_rd_data <= q_mem[qt_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int eps_after_decay(input int e);
        int n;
        n = e - e / 8;
        return (n < 16) ? 16 : n;
    endfunction

    function automatic logic [3:0] pick_action();
        logic [3:0] a;
        if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1010;
        else a = 4'b0001 << $urandom_range(0, 3);
        return a;
    endfunction

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!env_req && n < 40) begin @(negedge clk); n++; end
        ok = env_req;
        if (!ok) check_eq("env_req_timeout", 64'(env_req), 64'd1);
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!upd_valid && n < 40) begin @(negedge clk); n++; end
        ok = upd_valid;
        if (!ok) check_eq("upd_valid_timeout", 64'(upd_valid), 64'd1);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (!episode_done && n < 20) begin @(negedge clk); n++; end
        ok = episode_done;
        if (!ok) check_eq("episode_done_timeout", 64'(episode_done), 64'd1);
    endtask

    // One full training episode against the reference model
    task automatic run_episode(input logic [3:0] s0, input int done_at, input int rdy_fix);
        logic [3:0]  cur, nxt, plan, exp_act;
        logic [15:0] rew;
        logic        dn;
        int          steps, d;
        bit          last, ok;
        cur = s0; steps = 0; last = 0;
        plan = pick_action();
        pol_action = plan;
        start_state = s0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!last) begin
            exp_act = ($countones(plan) == 1) ? plan : 4'b0001;
            if ($countones(plan) != 1) m_act_err = 1'b1;
            wait_req(ok);
            if (!ok) return;
            check_eq("env_action", 64'(env_action), 64'(exp_act));
            check_eq("pol_q_values", pol_q_values, q_mem[cur]);
            check_eq("pol_epsilon", 64'(pol_epsilon), 64'(m_eps));
            check_eq("act_err", 64'(act_err), 64'(m_act_err));
            d = $urandom_range(0, 3);
            repeat (d) begin
                start = $urandom_range(0, 1);
                start_state = 4'($urandom_range(0, 15));
                env_reward = 16'($urandom);
                env_next_state = 4'($urandom_range(0, 15));
                env_done = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            nxt = 4'($urandom_range(0, 15));
            rew = 16'($urandom);
            dn = (steps == done_at);
            start = 1'b0;
            env_ack = 1'b1; env_reward = rew; env_next_state = nxt; env_done = dn;
            @(negedge clk);
            env_ack = 1'b0; env_reward = 16'($urandom); env_done = ~dn;
            check_eq("env_req_drop", 64'(env_req), 64'd0);
            wait_valid(ok);
            if (!ok) return;
            check_eq("upd_state", 64'(upd_state), 64'(cur));
            check_eq("upd_action", 64'(upd_action), 64'(exp_act));
            check_eq("upd_reward", 64'(upd_reward), 64'(rew));
            check_eq("upd_q_cur", upd_q_cur, q_mem[cur]);
            check_eq("upd_q_next", upd_q_next, q_mem[nxt]);
            d = (rdy_fix >= 0) ? rdy_fix : $urandom_range(0, 2);
            repeat (d) begin
                @(negedge clk);
                check_eq("upd_hold_valid", 64'(upd_valid), 64'd1);
                check_eq("upd_hold_reward", 64'(upd_reward), 64'(rew));
                check_eq("upd_hold_q_next", upd_q_next, q_mem[nxt]);
            end
            upd_ready = 1'b1;
            steps++;
            last = dn || (steps == MAXS);
            if (!last) begin
                cur = nxt;
                plan = pick_action();
                pol_action = plan;
            end
            @(negedge clk);
            upd_ready = 1'b0;
            check_eq("upd_valid_drop", 64'(upd_valid), 64'd0);
            check_eq("step_count", 64'(step_count), 64'(steps));
        end
        wait_done(ok);
        if (!ok) return;
        m_eps = eps_after_decay(m_eps);
        check_eq("epsilon_decay", 64'(epsilon), 64'(m_eps));
        check_eq("busy_end", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("done_pulse", 64'(episode_done), 64'd0);
    endtask

    initial begin
        bit ok;
        int t0;
        n_vec = 0; n_err = 0; cyc = 0;
        m_eps = 16'h00E0; m_act_err = 1'b0;
        for (int i = 0; i < 16; i++) q_mem[i] = {$urandom, $urandom};
        rst_n = 1'b0; start = 1'b0; start_state = '0; abort = 1'b0;
        pol_action = 4'b0001; env_ack = 1'b0; env_reward = '0;
        env_next_state = '0; env_done = 1'b0; upd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_env_req", 64'(env_req), 64'd0);
        check_eq("rst_upd_valid", 64'(upd_valid), 64'd0);
        check_eq("rst_qt_rd_en", 64'(qt_rd_en), 64'd0);
        check_eq("rst_epsilon", 64'(epsilon), 64'h00E0);
        check_eq("rst_pol_epsilon", 64'(pol_epsilon), 64'h00E0);
        check_eq("rst_step_count", 64'(step_count), 64'd0);
        check_eq("rst_act_err", 64'(act_err), 64'd0);
        check_eq("rst_upd_q_cur", upd_q_cur, 64'd0);

        // Directed single zero-wait step, done on first step
        q_mem[2] = 64'h000C_0001_0002_0003;
        pol_action = 4'b0100; start_state = 4'd2; upd_ready = 1'b1;
        start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        env_ack = 1'b1; env_reward = 16'h0100; env_next_state = 4'd5; env_done = 1'b1;
        @(negedge clk);
        env_ack = 1'b0; env_done = 1'b0;
        wait_valid(ok);
        check_eq("step_latency", 64'(cyc - t0), 64'd7);
        check_eq("d_upd_state", 64'(upd_state), 64'd2);
        check_eq("d_upd_action", 64'(upd_action), 64'b0100);
        check_eq("d_upd_reward", 64'(upd_reward), 64'h0100);
        check_eq("d_upd_q_cur", upd_q_cur, 64'h000C_0001_0002_0003);
        check_eq("d_upd_q_next", upd_q_next, q_mem[5]);
        @(negedge clk);
        upd_ready = 1'b0;
        wait_done(ok);
        check_eq("d_epsilon", 64'(epsilon), 64'h00C4);
        m_eps = 16'h00C4;
        @(negedge clk);
        check_eq("d_done_pulse", 64'(episode_done), 64'd0);

        // Bad action then abort during UPDATE
        pol_action = 4'b0110; start_state = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        m_act_err = 1'b1;
        check_eq("bad_env_action", 64'(env_action), 64'b0001);
        check_eq("bad_act_err", 64'(act_err), 64'd1);
        env_ack = 1'b1; env_next_state = 4'd3; env_done = 1'b0;
        @(negedge clk);
        env_ack = 1'b0;
        wait_valid(ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_upd_valid", 64'(upd_valid), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_epsilon", 64'(epsilon), 64'(m_eps));
        check_eq("abort_act_err", 64'(act_err), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", 64'(episode_done), 64'd0);
        check_eq("abort_epsilon_hold", 64'(epsilon), 64'(m_eps));

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", 64'(busy), 64'd0);
        check_eq("start_abort_rd_en", 64'(qt_rd_en), 64'd0);
        @(negedge clk);

        // Randomized episodes; first one has a fixed 5-cycle ready stall
        for (int e = 0; e < 30; e++) begin
            run_episode(4'($urandom_range(0, 15)), $urandom_range(0, 4), (e == 0) ? 5 : -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check_eq("eps_floor", 64'(epsilon), 64'h0010);

        // Reset while the environment request is outstanding
        pol_action = 4'b0010; start_state = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_env_req", 64'(env_req), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_epsilon", 64'(epsilon), 64'h00E0);
        check_eq("rst_mid_act_err", 64'(act_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
